bcd_display_driver: RTL

- Consumes the 10-digit packed BCD magnitude and sign bit from the binary-to-BCD converter and renders them right-aligned onto a multiplexed 7-segment display of DIGITS positions.
- Performs leading-zero blanking, places the minus sign, and detects overflow.
- Continuously time-multiplexes the anodes from a committed display buffer.
- Sits between the converter and the board pins; the display controller's NUMBER command path ends here.

---
 rtl/bcd_display_driver.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bcd_display_driver.sv
// ---------------------------------------------------------------------------
// bcd_display_driver
//
// Formats a 10-digit packed BCD magnitude plus sign right-aligned onto a
// multiplexed, active-low 7-segment display of DIGITS positions, and
// continuously scans the anodes from a committed display buffer.
//
// A load is formatted in two phases:
//   SCAN : 10 cycles, nibble index 9 down to 0, finds the most significant
//          nonzero nibble (msd). Nibbles above 9 count as nonzero.
//   FILL : DIGITS cycles, writes one shadow-buffer position per cycle. The
//          shadow buffer is copied to the committed buffer on the edge that
//          ends the last FILL cycle, so the display never sees a half-built
//          frame.
//
// Build option:
//   BCD_DISP_LZB_EN defined   : leading-zero blanking, minus sign placed just
//                               left of the most significant digit.
//   BCD_DISP_LZB_EN undefined : zero-padded, minus sign in the leftmost
//                               position. Overflow still uses the true msd.
//
// Handshake: load is accepted only in a cycle where ready=1 (and rst=0).
// ready stays low for 10+DIGITS cycles after acceptance; done pulses for one
// cycle together with ready returning high. Loads while busy are dropped.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset (wins over load)
//   load  in   one-cycle format request
//   bcd   in   40-bit packed BCD, digit k at bcd[4k+3:4k]
//   sign  in   1 = negative
//   ready out  high while idle
//   done  out  one-cycle pulse when a new frame is committed
//   seg   out  active-low segments, seg[0..6] = a..g, seg[7] = dp (off)
//   an    out  active-low one-hot anode select, position 0 rightmost
// ---------------------------------------------------------------------------
module bcd_display_driver #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [39:0]       bcd,
    input  logic              sign,
    output logic              ready,
    output logic              done,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;  // g only
    localparam logic [7:0] SEG_E     = 8'h86;  // a,d,e,f,g

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FILL
    } state_t;

    // Active-low digit patterns; nibbles above 9 render blank.
    function automatic logic [7:0] digit_seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [39:0]        bcd_q, bcd_d;
    logic               sign_q, sign_d;
    logic [3:0]         msd_q, msd_d;
    logic               found_q, found_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic [7:0]         shadow_q [DIGITS];
    logic [7:0]         shadow_d [DIGITS];
    logic [7:0]         disp_q [DIGITS];
    logic [7:0]         disp_d [DIGITS];
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         seg_q, seg_d;
    logic [DIGITS-1:0]  an_q, an_d;

    logic [3:0]         nib;
    logic [4:0]         len;
    logic               overflow;
    logic [3:0]         fill_msd;
    logic [7:0]         glyph;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        bcd_d    = bcd_q;
        sign_d   = sign_q;
        msd_d    = msd_q;
        found_d  = found_q;
        ready_d  = ready_q;
        done_d   = 1'b0;
        shadow_d = shadow_q;
        disp_d   = disp_q;

        // Nibble currently addressed by idx (SCAN index or FILL position).
        nib = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (idx_q == 4'(k)) begin
                nib = bcd_q[4*k +: 4];
            end
        end

        len      = {1'b0, msd_q} + 5'd1 + {4'b0, sign_q};
        overflow = (len > 5'(DIGITS));

`ifdef BCD_DISP_LZB_EN
        fill_msd = msd_q;
`else
        // Zero padding: every position left of the sign slot shows a digit.
        fill_msd = 4'(DIGITS - 1) - {3'b0, sign_q};
`endif

        if (overflow) begin
            glyph = SEG_E;
        end else if (idx_q <= fill_msd) begin
            glyph = digit_seg(nib);
        end else if (sign_q && (idx_q == fill_msd + 4'd1)) begin
            glyph = SEG_MINUS;
        end else begin
            glyph = SEG_BLANK;
        end

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    bcd_d   = bcd;
                    sign_d  = sign;
                    idx_d   = 4'd9;
                    msd_d   = 4'd0;
                    found_d = 1'b0;
                    ready_d = 1'b0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // Walking downward, the first nonzero nibble is the msd.
                if (!found_q && (nib != 4'd0)) begin
                    msd_d   = idx_q;
                    found_d = 1'b1;
                end
                if (idx_q == 4'd0) begin
                    state_d = ST_FILL;
                end else begin
                    idx_d = idx_q - 4'd1;
                end
            end
            ST_FILL: begin
                for (int p = 0; p < DIGITS; p++) begin
                    if (idx_q == 4'(p)) begin
                        shadow_d[p] = glyph;
                    end
                end
                if (idx_q == 4'(DIGITS - 1)) begin
                    // Commit includes the position written this cycle.
                    disp_d  = shadow_d;
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                    idx_d   = 4'd0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase

        // Anode scan, free running regardless of the formatter.
        pre_d = pre_q + 1'b1;
        ptr_d = ptr_q;
        if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_d = '0;
            if (ptr_q == PTR_W'(DIGITS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end

        // an and seg are both derived from the next pointer and next
        // committed frame so they always change on the same edge.
        an_d  = '1;
        seg_d = SEG_BLANK;
        for (int p = 0; p < DIGITS; p++) begin
            if (ptr_d == PTR_W'(p)) begin
                an_d[p] = 1'b0;
                seg_d   = disp_d[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= 4'd0;
            bcd_q    <= '0;
            sign_q   <= 1'b0;
            msd_q    <= 4'd0;
            found_q  <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            shadow_q <= '{default: SEG_BLANK};
            disp_q   <= '{default: SEG_BLANK};
            pre_q    <= '0;
            ptr_q    <= '0;
            seg_q    <= SEG_BLANK;
            an_q     <= ~(DIGITS'(1));
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            bcd_q    <= bcd_d;
            sign_q   <= sign_d;
            msd_q    <= msd_d;
            found_q  <= found_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            pre_q    <= pre_d;
            ptr_q    <= ptr_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign seg   = seg_q;
    assign an    = an_q;

endmodule
